// File: rtl/myproject_dense_acc_pkg.sv
// Shared constants and FSM state type for the dense-layer accumulator/requantizer.
package myproject_dense_acc_pkg;
    localparam int N_IN   = 16;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 6;
    localparam int CNT_W  = $clog2(N_IN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;
endpackage

// File: rtl/myproject_requant.sv
// Combinational ReLU, round-half-up right shift and unsigned saturation.
module myproject_requant #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 6,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] s_i,
    output logic        [OUT_W-1:0] r_o
);
    localparam int AW1 = ACC_W + 1;
    localparam logic signed [ACC_W:0] HALF = AW1'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV = AW1'((1 << OUT_W) - 1);

    logic signed [ACC_W:0] t_w;

    // One guard bit so the rounding add cannot wrap near the top of the range
    assign t_w = ($signed({s_i[ACC_W-1], s_i}) + HALF) >>> SHIFT;

    always_comb begin
        r_o = '0;
        if (s_i[ACC_W-1]) begin
            r_o = '0;
        end else if (t_w > MAXV) begin
            r_o = '1;
        end else begin
            r_o = t_w[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/myproject_dense_acc.sv
// Sums N_IN signed products plus bias per neuron, requantizes to an unsigned activation.
module myproject_dense_acc #(
    parameter int N_IN   = myproject_dense_acc_pkg::N_IN,
    parameter int PROD_W = myproject_dense_acc_pkg::PROD_W,
    parameter int ACC_W  = myproject_dense_acc_pkg::ACC_W,
    parameter int OUT_W  = myproject_dense_acc_pkg::OUT_W,
    parameter int SHIFT  = myproject_dense_acc_pkg::SHIFT,
    parameter logic signed [ACC_W-1:0] BIAS = '0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic        [OUT_W-1:0]  res_data,
    output logic                     res_valid,
    input  logic                     res_ready
);
    import myproject_dense_acc_pkg::*;

    localparam int CW = $clog2(N_IN);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CW-1:0]    cnt_q, cnt_d;
    logic        [OUT_W-1:0] res_data_q, res_data_d;
    logic                    res_valid_q, res_valid_d;

    logic signed [ACC_W-1:0] prod_ext_w;
    logic signed [ACC_W-1:0] sum_w;
    logic        [OUT_W-1:0] req_w;

    assign prod_ext_w = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    // Bias folds into the final product's add so it lands exactly once per neuron
    assign sum_w      = acc_q + prod_ext_w + BIAS;

    myproject_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_requant (
        .s_i (sum_w),
        .r_o (req_w)
    );

    assign prod_ready = (state_q == ACCUM);
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        case (state_q)
            ACCUM: begin
                if (prod_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        res_data_d  = req_w;
                        res_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = acc_q + prod_ext_w;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end
endmodule

// File: tb/tb_myproject_dense_acc.sv
// Directed and randomized neurons against an arithmetic model; two instances cover BIAS=0 and BIAS=-96.
module tb_myproject_dense_acc;
    localparam int N_IN  = 4;
    localparam int SHIFT = 6;
    localparam int OUT_W = 8;
    localparam int BIAS_B = -96;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [15:0] prod_data;
    logic               prod_valid;
    logic               res_ready;
    logic               prod_ready_a, prod_ready_b;
    logic [7:0]         res_data_a, res_data_b;
    logic               res_valid_a, res_valid_b;

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_dense_acc #(.N_IN(N_IN), .PROD_W(16), .ACC_W(24), .OUT_W(OUT_W), .SHIFT(SHIFT),
                          .BIAS(24'sd0)) dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready_a), .res_data(res_data_a), .res_valid(res_valid_a), .res_ready(res_ready));

    myproject_dense_acc #(.N_IN(N_IN), .PROD_W(16), .ACC_W(24), .OUT_W(OUT_W), .SHIFT(SHIFT),
                          .BIAS(-24'sd96)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready_b), .res_data(res_data_b), .res_valid(res_valid_b), .res_ready(res_ready));

    // ReLU, round half up by 2^SHIFT, clamp to the 8-bit unsigned range
    function automatic int model(input int s);
        int t;
        if (s < 0) return 0;
        t = (s + (1 << (SHIFT - 1))) / (1 << SHIFT);
        return (t > 255) ? 255 : t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Feeds four products; returns with time one cycle after the final accept.
    task automatic run_neuron(input string tag, input int p0, input int p1, input int p2, input int p3,
                              input bit sparse, output int exp_a, output int exp_b);
        int p[4];
        int s;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (sparse) begin
                prod_valid = 1'b0;
                prod_data  = 16'($urandom);
                tick();
            end
            chk({tag, "_rdy_before"}, 32'(prod_ready_a & prod_ready_b), 32'd1);
            chk({tag, "_vld_before"}, 32'(res_valid_a | res_valid_b), 32'd0);
            prod_valid = 1'b1;
            prod_data  = 16'(p[i]);
            s += p[i];
            tick();
        end
        prod_valid = 1'b0;
        exp_a = model(s);
        exp_b = model(s + BIAS_B);
        chk({tag, "_vld_a"}, 32'(res_valid_a), 32'd1);
        chk({tag, "_vld_b"}, 32'(res_valid_b), 32'd1);
        chk({tag, "_data_a"}, 32'(res_data_a), 32'(exp_a));
        chk({tag, "_data_b"}, 32'(res_data_b), 32'(exp_b));
        chk({tag, "_rdy_hold"}, 32'(prod_ready_a | prod_ready_b), 32'd0);
        if (res_ready) begin
            tick();
            chk({tag, "_vld_drop"}, 32'(res_valid_a | res_valid_b), 32'd0);
            chk({tag, "_rdy_back"}, 32'(prod_ready_a & prod_ready_b), 32'd1);
            chk({tag, "_data_keep"}, 32'(res_data_a), 32'(exp_a));
        end
    endtask

    initial begin
        int ea, eb;
        int r[4];
        ap_rst_n   = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        res_ready  = 1'b1;
        #2;
        chk("rst_vld", 32'(res_valid_a | res_valid_b), 32'd0);
        chk("rst_data", 32'(res_data_a | res_data_b), 32'd0);
        chk("rst_rdy", 32'(prod_ready_a & prod_ready_b), 32'd1);
        // products offered during reset must not be counted
        prod_valid = 1'b1;
        prod_data  = 16'sd5000;
        repeat (3) @(posedge ap_clk);
        prod_valid = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();

        run_neuron("base", 100, 200, 300, 400, 1'b0, ea, eb);
        chk("base_val", 32'(ea), 32'd16);
        run_neuron("relu", -500, -500, -500, -500, 1'b0, ea, eb);
        run_neuron("sat", 16000, 16000, 16000, 16000, 1'b0, ea, eb);
        chk("sat_val", 32'(ea), 32'd255);
        run_neuron("rnd96", 24, 24, 24, 24, 1'b0, ea, eb);
        chk("rnd96_val", 32'(ea), 32'd2);
        chk("bias96_val", 32'(eb), 32'd0);
        run_neuron("rnd95", 23, 24, 24, 24, 1'b0, ea, eb);
        chk("rnd95_val", 32'(ea), 32'd1);

        // backpressure: result must hold and offered products stay unconsumed
        res_ready = 1'b0;
        run_neuron("bp", 100, 200, 300, 400, 1'b0, ea, eb);
        for (int i = 0; i < 5; i++) begin
            prod_valid = 1'b1;
            prod_data  = 16'sd9999;
            tick();
            chk("bp_vld_stable", 32'(res_valid_a & res_valid_b), 32'd1);
            chk("bp_data_stable", 32'(res_data_a), 32'(ea));
            chk("bp_rdy_low", 32'(prod_ready_a | prod_ready_b), 32'd0);
        end
        prod_valid = 1'b0;
        res_ready  = 1'b1;
        tick();
        chk("bp_release_vld", 32'(res_valid_a | res_valid_b), 32'd0);
        chk("bp_release_rdy", 32'(prod_ready_a & prod_ready_b), 32'd1);
        run_neuron("bp_after", 24, 24, 24, 24, 1'b0, ea, eb);

        run_neuron("sparse", 100, 200, 300, 400, 1'b1, ea, eb);
        chk("sparse_val", 32'(ea), 32'd16);

        // asynchronous reset mid-neuron drops the partial sum
        prod_valid = 1'b1;
        prod_data  = 16'sd1000;
        tick();
        tick();
        prod_valid = 1'b0;
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(res_valid_a | res_valid_b), 32'd0);
        chk("mid_rst_rdy", 32'(prod_ready_a & prod_ready_b), 32'd1);
        @(posedge ap_clk);
        #4;
        ap_rst_n = 1'b1;
        tick();
        chk("post_rst_vld", 32'(res_valid_a | res_valid_b), 32'd0);
        run_neuron("post_rst", 64, 64, 64, 64, 1'b0, ea, eb);
        chk("post_rst_val", 32'(ea), 32'd4);
        chk("post_rst_bias", 32'(eb), 32'd3);

        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 4; k++)
                r[k] = (n % 3 == 2) ? int'($urandom_range(0, 30000)) : int'($urandom_range(0, 8000)) - 4000;
            run_neuron("rand", r[0], r[1], r[2], r[3], 1'($urandom_range(0, 1)), ea, eb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/myproject_dense_acc.md
# myproject_dense_acc

Accumulator/requantizer stage placed directly downstream of the 8-bit unsigned × 8-bit signed, 16-bit-product multiplier in a dense layer. It sums N_IN signed products for one output neuron and adds a constant bias. It then applies ReLU, round-half-up right shift and unsigned saturation. The result is an 8-bit unsigned activation, the operand format the next layer's multiplier consumes.

## Interface
- N_IN, 16, products per output neuron (≥2)
- PROD_W, 16, signed product width
- ACC_W, 24, signed accumulator width; must satisfy ACC_W ≥ PROD_W + clog2(N_IN) + 1
- OUT_W, 8, unsigned activation width
- SHIFT, 6, fractional bits dropped during requantization (≥1)
- BIAS, 0, signed ACC_W-bit constant added once per neuron

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  reset; asynchronous, active-low
- prod_data  in  PROD_W  signed product from the multiplier
- prod_valid  in  1  prod_data is valid
- prod_ready  out  1  block accepts a product this cycle
- res_data  out  OUT_W  unsigned activation
- res_valid  out  1  res_data is valid
- res_ready  in  1  downstream accepts the result

## Operation
- There are two states, ACCUM and HOLD. Reset state is ACCUM.
- Reset values while ap_rst_n is low: acc=0, cnt=0, res_valid=0, res_data=0, prod_ready=1.
- No transfers are recognised while ap_rst_n is low.
- prod_ready equals (state==ACCUM). It is a pure state decode, with no combinational path from res_ready.
- ACCUM state, on a product accept (prod_valid & prod_ready):
  - If cnt<N_IN-1: acc += sext(prod_data); cnt++.
  - If cnt==N_IN-1: S = acc + sext(prod_data) + BIAS. Register R = requant(S) into res_data. Set res_valid=1. Clear acc and cnt. Go to HOLD.
- HOLD state, when res_valid & res_ready: res_valid←0 and go to ACCUM. res_data keeps its last value.
- requant(S):
  - If S<0: result 0 (ReLU).
  - Otherwise T=(S + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits so the add never wraps.
  - If T > 2^OUT_W-1: result 2^OUT_W-1. Otherwise result T[OUT_W-1:0].
- The accumulator never wraps; the ACC_W constraint guarantees this. The implementation does not check for overflow.
- A reset asserted mid-neuron discards the partial sum and any pending result. No output is produced for that neuron.

## Timing
- Product accept to res_valid high: 1 cycle, counted from the edge that accepts the N_IN-th product.
- res_data and res_valid are registered outputs. They are stable while res_valid=1 and res_ready=0.
- Minimum period per neuron is N_IN+1 cycles: N_IN accepts plus one HOLD cycle with res_ready=1.
- Gaps in prod_valid stall the count with no state change.
- prod_data is ignored when prod_valid=0 or prod_ready=0.

## Structure
- Package myproject_dense_acc_pkg holds:
  - default constants N_IN, PROD_W, ACC_W, OUT_W, SHIFT
  - state typedef enum {ACCUM, HOLD}
  - localparam CNT_W = clog2(N_IN)
- Sub-module myproject_requant: combinational ReLU, round and saturate, parameterised by ACC_W, SHIFT and OUT_W. It can be unit-tested standalone.
- The top module holds the accumulator, counter, FSM and output register.

## Test plan
All scenarios use N_IN=4, SHIFT=6, OUT_W=8 and BIAS=0 unless stated otherwise.
- Products 100,200,300,400 back-to-back, res_ready=1 → res_data=16 one cycle after the 4th accept; prod_ready low for exactly 1 cycle.
- Products -500 ×4 (S=-2000) → res_data=0. Products 16000 ×4 (T=1000) → res_data=255.
- Rounding: products 24 ×4 (S=96) → 2. Products 23,24,24,24 (S=95) → 1. With BIAS=-96, products 24 ×4 → 0.
- Backpressure: res_ready held low 5 cycles after res_valid rises → res_data/res_valid stable, prod_ready=0, a product offered meanwhile is not consumed. res_ready=1 → accept resumes on the next cycle.
- Sparse input: prod_valid toggled every other cycle → same result as the back-to-back case (16), with latency measured from the last accept.
- Reset mid-neuron: accept 2 products of 1000, pulse ap_rst_n low asynchronously (between clock edges) → res_valid=0 and no result emitted. Then products 64 ×4 → res_data=4.
